// File: rtl/uart_rx_scoreboard_pkg.sv
// Shared types and LFSR step for the UART loopback pattern generator and receive scoreboard.
package uart_tb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int         LFSR_W            = 8;
   localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;

   // Fibonacci step, taps 8/6/5/4; an all-zero state would lock up, so seeds are never zero.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

endpackage

// File: rtl/uart_rx_scoreboard_if.sv
// Byte stream from the UART receiver into the scoreboard.
interface uart_rx_scoreboard_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_frame_err;

   modport master (output rx_valid, output rx_data, output rx_frame_err);
   modport slave  (input  rx_valid, input  rx_data, input  rx_frame_err);
endinterface

// File: rtl/uart_pattern_lfsr.sv
// 8-bit pattern LFSR with load and advance; shared by the pattern generator and the scoreboard.
module uart_pattern_lfsr
   import uart_tb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= LFSR_SEED_DEFAULT;
      end else if (load) begin
         value <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
      end else if (advance) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/uart_rx_scoreboard.sv
// Receive-side checker: compares received bytes against the LFSR pattern, counts errors.
// Optional idle watchdog enabled by defining SCOREBOARD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting and checking bytes
// DONE  | run complete; further bytes are overruns
module uart_rx_scoreboard
   import uart_tb_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            seed,
   input  logic [15:0]           num_bytes,
   uart_rx_scoreboard_if.slave   rx,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  mismatch,
   output logic                  timeout,
   output logic [CNT_W-1:0]      error_count,
   output logic [15:0]           byte_count
);

   state_e      state, state_nxt;
   logic [15:0] num_r;
   logic [7:0]  exp_byte;
   logic        byte_err, accept, overrun, timeout_hit, err_inc;

   uart_pattern_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .seed    (seed),
      .advance (accept),
      .value   (exp_byte)
   );

   assign byte_err = (rx.rx_data != exp_byte) | rx.rx_frame_err;
   assign accept   = (state == RUN) && rx.rx_valid && !start && (byte_count != num_r);
   // A byte arriving in the last RUN cycle, after the count is already met, is an overrun too.
   assign overrun  = rx.rx_valid && !start &&
                     ((state == DONE) || ((state == RUN) && (byte_count == num_r)));
   assign err_inc  = (accept && byte_err) || overrun || timeout_hit;

`ifdef SCOREBOARD_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout_r;

   assign timeout_hit = (state == RUN) && !start && !rx.rx_valid &&
                        (idle_cnt == IDLE_W'(TIMEOUT_CYC));
   assign timeout     = timeout_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt  <= '0;
         timeout_r <= 1'b0;
      end else if (start) begin
         idle_cnt  <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (rx.rx_valid) begin
            idle_cnt <= '0;
         end else if ((state == RUN) && (idle_cnt != IDLE_W'(TIMEOUT_CYC))) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
         if (timeout_hit) begin
            timeout_r <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   // Always false; keeps TIMEOUT_CYC referenced in the build without the watchdog.
   assign timeout     = (TIMEOUT_CYC < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = (num_bytes == '0) ? DONE : RUN;
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            RUN:  if (timeout_hit || (byte_count == num_r)) state_nxt = DONE;
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_r       <= '0;
         error_count <= '0;
         byte_count  <= '0;
         mismatch    <= 1'b0;
      end else if (start) begin
         num_r       <= num_bytes;
         error_count <= '0;
         byte_count  <= '0;
         mismatch    <= 1'b0;
      end else begin
         mismatch <= (accept && byte_err) || overrun;
         if (err_inc && (error_count != '1)) begin
            error_count <= error_count + CNT_W'(1);
         end
         if (accept) begin
            byte_count <= byte_count + 16'd1;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = (state == DONE) && (error_count == '0);

endmodule

// File: tb/tb_uart_rx_scoreboard.sv
// Scoreboard bench for uart_rx_scoreboard: randomized byte streams against a queue-based reference.
module tb_uart_rx_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  seed;
   logic [15:0] num_bytes;

   always #5 clk = ~clk;

   uart_rx_scoreboard_if rx_a ();
   uart_rx_scoreboard_if rx_b ();

   logic        busy_a, done_a, pass_a, mismatch_a, timeout_a;
   logic [15:0] error_count_a, byte_count_a;
   logic        busy_b, done_b, pass_b, mismatch_b, timeout_b;
   logic [3:0]  error_count_b;
   logic [15:0] byte_count_b;

   uart_rx_scoreboard #(.CNT_W(16), .TIMEOUT_CYC(100)) dut_a (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .num_bytes(num_bytes), .rx(rx_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch(mismatch_a), .timeout(timeout_a),
      .error_count(error_count_a), .byte_count(byte_count_a)
   );

   uart_rx_scoreboard #(.CNT_W(4), .TIMEOUT_CYC(100)) dut_b (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .num_bytes(num_bytes), .rx(rx_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch(mismatch_b), .timeout(timeout_b),
      .error_count(error_count_b), .byte_count(byte_count_b)
   );

   typedef struct {
      bit mm;
      int ec;
      int bc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference: sequence generator defined by tap mask 0xB8 (bits 7,5,4,3) feeding bit 0.
   int         m_state;   // 0 idle, 1 run, 2 done
   logic [7:0] m_lfsr;
   int         m_n, m_bc, m_ec;

   function automatic logic [7:0] ref_next(input logic [7:0] v);
      return (v << 1) | 8'(^(v & 8'hB8));
   endfunction

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rx(input logic v, input logic [7:0] d, input logic fe);
      rx_a.rx_valid = v; rx_a.rx_data = d; rx_a.rx_frame_err = fe;
      rx_b.rx_valid = v; rx_b.rx_data = d; rx_b.rx_frame_err = fe;
   endtask

   task automatic do_start(input logic [7:0] s, input logic [15:0] n, input bit with_byte);
      seed = s; num_bytes = n; start = 1'b1;
      if (with_byte) drive_rx(1'b1, 8'($urandom), 1'b0);
      m_lfsr  = (s == 8'h00) ? 8'h01 : s;
      m_n     = n;
      m_bc    = 0;
      m_ec    = 0;
      m_state = (n == 0) ? 2 : 1;
      cyc();
      start = 1'b0;
      drive_rx(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send(input logic [7:0] d, input logic fe);
      bit err;
      drive_rx(1'b1, d, fe);
      if (m_state == 1) begin
         err = (d != m_lfsr) || fe;
         m_bc++;
         m_lfsr = ref_next(m_lfsr);
         if (err) m_ec++;
         exp_q.push_back('{err, m_ec, m_bc});
         if (m_bc == m_n) m_state = 2;
      end else if (m_state == 2) begin
         m_ec++;
         exp_q.push_back('{1'b1, m_ec, m_bc});
      end
      cyc();
      drive_rx(1'b0, 8'h00, 1'b0);
      cyc();
   endtask

   task automatic end_check(input string name);
      for (int i = 0; i < 20 && !done_a; i++) cyc();
      check({name, "_done"}, done_a, 1);
      check({name, "_pass"}, pass_a, (m_ec == 0));
      check({name, "_err_cnt"}, error_count_a, sat(m_ec, 65535));
      check({name, "_byte_cnt"}, byte_count_a, m_bc);
      check({name, "_err_cnt_w4"}, error_count_b, sat(m_ec, 15));
   endtask

   // Monitor: one reference entry per accepted byte or overrun on the wide instance.
   logic [15:0] prev_bc;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_bc = '0;
      end else begin
         if (mismatch_a || (byte_count_a != prev_bc && byte_count_a != 16'd0)) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: mismatch=%0d byte_count=%0d with no expected entry",
                        mismatch_a, byte_count_a);
            end else begin
               e = exp_q.pop_front();
               check("mon_mismatch", mismatch_a, e.mm);
               check("mon_err_cnt", error_count_a, sat(e.ec, 65535));
               check("mon_byte_cnt", byte_count_a, e.bc);
            end
         end
         prev_bc = byte_count_a;
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; seed = '0; num_bytes = '0;
      drive_rx(1'b0, 8'h00, 1'b0);
      m_state = 0; m_lfsr = 8'h01; m_n = 0; m_bc = 0; m_ec = 0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_pass", pass_a, 0);
      check("rst_mismatch", mismatch_a, 0);
      check("rst_timeout", timeout_a, 0);
      check("rst_err_cnt", error_count_a, 0);
      check("rst_byte_cnt", byte_count_a, 0);

      // rx in IDLE is ignored
      send(8'h55, 1'b1);
      check("idle_byte_cnt", byte_count_a, 0);

      // T1 clean run
      do_start(8'hA5, 16, 0);
      check("t1_busy", busy_a, 1);
      for (int i = 0; i < 16; i++) send(m_lfsr, 1'b0);
      end_check("t1");

      // T2 data corruption on byte 3, frame error on byte 9
      do_start(8'hA5, 16, 0);
      for (int i = 0; i < 16; i++) send((i == 3) ? (m_lfsr ^ 8'h01) : m_lfsr, (i == 9));
      end_check("t2");
      check("t2_err_cnt_lit", error_count_a, 2);

      // T3 double fault counts once, then one overrun
      do_start(8'h3C, 16, 0);
      for (int i = 0; i < 16; i++) send((i == 0) ? ~m_lfsr : m_lfsr, (i == 0));
      end_check("t3a");
      send(8'($urandom), 1'b0);
      end_check("t3b");
      check("t3_err_cnt_lit", error_count_a, 2);

      // T4 saturation on the narrow instance
      do_start(8'($urandom_range(1, 255)), 20, 0);
      for (int i = 0; i < 20; i++) send(m_lfsr ^ 8'($urandom_range(1, 255)), 1'b0);
      end_check("t4");
      check("t4_sat_lit", error_count_b, 15);

      // T5 restart mid-run, zero seed, zero-length run, start beating a coincident byte
      do_start(8'h77, 10, 0);
      for (int i = 0; i < 5; i++) send(m_lfsr, 1'b0);
      do_start(8'h00, 3, 1);
      check("t5_cleared", byte_count_a, 0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h04, 1'b0);
      end_check("t5");
      check("t5_pass_lit", pass_a, 1);
      do_start(8'h9E, 0, 0);
      check("t5_zero_done", done_a, 1);
      check("t5_zero_pass", pass_a, 1);
      check("t5_zero_busy", busy_a, 0);

      // Randomized runs
      for (int r = 0; r < 8; r++) begin
         do_start(8'($urandom), 16'($urandom_range(1, 30)), ($urandom_range(0, 1) == 1));
         while (m_state == 1) begin
            send(($urandom_range(0, 3) == 0) ? (m_lfsr ^ 8'($urandom_range(1, 255))) : m_lfsr,
                 ($urandom_range(0, 6) == 0));
         end
         end_check("rand");
         if ($urandom_range(0, 1) == 1) begin
            send(8'($urandom), 1'($urandom));
            end_check("rand_overrun");
         end
      end

      // T6 silence after 2 of 4 bytes
      do_start(8'h11, 4, 0);
      send(m_lfsr, 1'b0);
      send(m_lfsr, 1'b0);
      repeat (150) cyc();
`ifdef SCOREBOARD_TIMEOUT_EN
      check("t6_timeout", timeout_a, 1);
      check("t6_done", done_a, 1);
      check("t6_err_cnt", error_count_a, 1);
      check("t6_byte_cnt", byte_count_a, 2);
      check("t6_err_cnt_w4", error_count_b, 1);
      do_start(8'h22, 1, 0);
      check("t6_timeout_clr", timeout_a, 0);
`else
      check("t6_busy", busy_a, 1);
      check("t6_timeout", timeout_a, 0);
      check("t6_done", done_a, 0);
      check("t6_byte_cnt", byte_count_a, 2);
`endif

      repeat (2) cyc();
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
